// File: rtl/y86_pkg.sv
// Shared Y86 writeback types: register ids, queue entry layout and
// the per-path write-enable rules used by both the queue and the issue stage.
package y86_pkg;

  typedef logic [3:0] reg_id_t;

  localparam reg_id_t RNONE = 4'hF;
  localparam reg_id_t RSP   = 4'hE;

  typedef struct packed {
    reg_id_t     dstE;
    logic [63:0] valE;
    reg_id_t     dstM;
    logic [63:0] valM;
  } wb_entry_t;

  // E path yields to M when both target the same register (popq %rsp)
  function automatic logic en_e(input reg_id_t dst_e, input reg_id_t dst_m);
    return (dst_e != RNONE) && (dst_e != dst_m);
  endfunction

  function automatic logic en_m(input reg_id_t dst_m);
    return (dst_m != RNONE);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Pending-writeback queue: circular storage with occupancy count.
// With WB_BYPASS_EN defined the stored values are also exported for forwarding.
module wb_fifo
  import y86_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  wb_entry_t      din,
  output wb_entry_t      head,
  output logic [CW-1:0]  count,
  output logic [PW-1:0]  rd_ptr,
  output reg_id_t        dst_e [DEPTH],
`ifdef WB_BYPASS_EN
  output logic [63:0]    val_e [DEPTH],
  output logic [63:0]    val_m [DEPTH],
`endif
  output reg_id_t        dst_m [DEPTH]
);

  wb_entry_t      mem_r [DEPTH];
  logic [PW-1:0]  wr_ptr_r;
  logic [PW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;

  // pointer and occupancy update; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      wr_ptr_r <= push ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
      rd_ptr_r <= pop  ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // entry storage; stale contents are harmless since count gates validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= din;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  assign head   = mem_r[rd_ptr_r];
  assign count  = count_r;
  assign rd_ptr = rd_ptr_r;

  for (genvar i = 0; i < DEPTH; i++) begin : g_tap
    assign dst_e[i] = mem_r[i].dstE;
    assign dst_m[i] = mem_r[i].dstM;
`ifdef WB_BYPASS_EN
    assign val_e[i] = mem_r[i].valE;
    assign val_m[i] = mem_r[i].valM;
`endif
  end

endmodule

// File: rtl/wb_issue.sv
// Writeback issue stage: queues retiring results, issues one E/M write pair per
// cycle and reports decode hazards. Optional forwarding under WB_BYPASS_EN.
module wb_issue
  import y86_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_dstE,
  input  logic [63:0] in_valE,
  input  logic [3:0]  in_dstM,
  input  logic [63:0] in_valM,
  output logic        wr_enA,
  output logic [3:0]  wr_dstA,
  output logic [63:0] wr_valA,
  output logic        wr_enB,
  output logic [3:0]  wr_dstB,
  output logic [63:0] wr_valB,
  input  logic        wb_hold,
  input  logic [3:0]  q_srcA,
  input  logic [3:0]  q_srcB,
  output logic        hazA,
  output logic        hazB,
`ifdef WB_BYPASS_EN
  output logic [63:0] fwdA_val,
  output logic [63:0] fwdB_val,
`endif
  output logic        idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic           push_s;
  logic           pop_s;
  wb_entry_t      din_s;
  wb_entry_t      head_s;
  logic [CW-1:0]  count_s;
  logic [PW-1:0]  rd_ptr_s;
  reg_id_t        dst_e_s [DEPTH];
  reg_id_t        dst_m_s [DEPTH];
`ifdef WB_BYPASS_EN
  logic [63:0]    val_e_s [DEPTH];
  logic [63:0]    val_m_s [DEPTH];
`endif

  logic           wra_en_r;
  reg_id_t        wra_dst_r;
  logic [63:0]    wra_val_r;
  logic           wrb_en_r;
  reg_id_t        wrb_dst_r;
  logic [63:0]    wrb_val_r;

  // a pop in the same cycle never opens a slot early: ready looks at count only
  assign in_ready = (count_s < CW'(DEPTH)) && !rst;
  assign push_s   = in_valid && in_ready;
  assign pop_s    = (count_s != CW'(0)) && !wb_hold && !rst;
  assign din_s    = '{dstE: in_dstE, valE: in_valE, dstM: in_dstM, valM: in_valM};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push_s),
    .pop    (pop_s),
    .din    (din_s),
    .head   (head_s),
    .count  (count_s),
    .rd_ptr (rd_ptr_s),
    .dst_e  (dst_e_s),
`ifdef WB_BYPASS_EN
    .val_e  (val_e_s),
    .val_m  (val_m_s),
`endif
    .dst_m  (dst_m_s)
  );

  // register-file write stage: enables pulse only on a pop, fields otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      wra_en_r  <= 1'b0;
      wra_dst_r <= RNONE;
      wra_val_r <= 64'd0;
      wrb_en_r  <= 1'b0;
      wrb_dst_r <= RNONE;
      wrb_val_r <= 64'd0;
    end else if (pop_s) begin
      wra_en_r  <= en_e(head_s.dstE, head_s.dstM);
      wra_dst_r <= head_s.dstE;
      wra_val_r <= head_s.valE;
      wrb_en_r  <= en_m(head_s.dstM);
      wrb_dst_r <= head_s.dstM;
      wrb_val_r <= head_s.valM;
    end else begin
      wra_en_r  <= 1'b0;
      wra_dst_r <= wra_dst_r;
      wra_val_r <= wra_val_r;
      wrb_en_r  <= 1'b0;
      wrb_dst_r <= wrb_dst_r;
      wrb_val_r <= wrb_val_r;
    end
  end

  assign wr_enA  = wra_en_r;
  assign wr_dstA = wra_dst_r;
  assign wr_valA = wra_val_r;
  assign wr_enB  = wrb_en_r;
  assign wr_dstB = wrb_dst_r;
  assign wr_valB = wrb_val_r;
  assign idle    = (count_s == CW'(0)) && !wra_en_r && !wrb_en_r;

  for (genvar p = 0; p < 2; p++) begin : g_port
    reg_id_t        q_s;
    logic           hit_s;
    logic           m_s;
    logic           live_s;
    logic [PW-1:0]  idx_s;
    logic [63:0]    fwd_s;

    assign q_s = (p == 0) ? q_srcA : q_srcB;

    // scan write stage, then queue oldest to youngest; later matches override
    always_comb begin
      hit_s  = 1'b0;
      fwd_s  = 64'd0;
      idx_s  = rd_ptr_s;
      live_s = 1'b0;
      m_s    = (q_s != RNONE) && wra_en_r && (wra_dst_r == q_s);
      hit_s  = hit_s | m_s;
      fwd_s  = m_s ? wra_val_r : fwd_s;
      m_s    = (q_s != RNONE) && wrb_en_r && (wrb_dst_r == q_s);
      hit_s  = hit_s | m_s;
      fwd_s  = m_s ? wrb_val_r : fwd_s;
      for (int k = 0; k < DEPTH; k++) begin
        idx_s  = rd_ptr_s + PW'(k);
        live_s = (CW'(k) < count_s) && (q_s != RNONE);
        m_s    = live_s && en_e(dst_e_s[idx_s], dst_m_s[idx_s]) && (dst_e_s[idx_s] == q_s);
        hit_s  = hit_s | m_s;
`ifdef WB_BYPASS_EN
        fwd_s  = m_s ? val_e_s[idx_s] : fwd_s;
`endif
        m_s    = live_s && en_m(dst_m_s[idx_s]) && (dst_m_s[idx_s] == q_s);
        hit_s  = hit_s | m_s;
`ifdef WB_BYPASS_EN
        fwd_s  = m_s ? val_m_s[idx_s] : fwd_s;
`endif
      end
    end
  end

  assign hazA = g_port[0].hit_s;
  assign hazB = g_port[1].hit_s;
`ifdef WB_BYPASS_EN
  assign fwdA_val = g_port[0].fwd_s;
  assign fwdB_val = g_port[1].fwd_s;
`endif

endmodule

// File: tb/tb_wb_issue.sv
// Directed self-checking bench for wb_issue (DEPTH=4); forwarding checks
// are included when WB_BYPASS_EN is defined.
module tb_wb_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_dstE;
  logic [63:0] in_valE;
  logic [3:0]  in_dstM;
  logic [63:0] in_valM;
  logic        wr_enA;
  logic [3:0]  wr_dstA;
  logic [63:0] wr_valA;
  logic        wr_enB;
  logic [3:0]  wr_dstB;
  logic [63:0] wr_valB;
  logic        wb_hold;
  logic [3:0]  q_srcA;
  logic [3:0]  q_srcB;
  logic        hazA;
  logic        hazB;
`ifdef WB_BYPASS_EN
  logic [63:0] fwdA_val;
  logic [63:0] fwdB_val;
`endif
  logic        idle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_issue #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_dstE  (in_dstE),
    .in_valE  (in_valE),
    .in_dstM  (in_dstM),
    .in_valM  (in_valM),
    .wr_enA   (wr_enA),
    .wr_dstA  (wr_dstA),
    .wr_valA  (wr_valA),
    .wr_enB   (wr_enB),
    .wr_dstB  (wr_dstB),
    .wr_valB  (wr_valB),
    .wb_hold  (wb_hold),
    .q_srcA   (q_srcA),
    .q_srcB   (q_srcB),
    .hazA     (hazA),
    .hazB     (hazB),
`ifdef WB_BYPASS_EN
    .fwdA_val (fwdA_val),
    .fwdB_val (fwdB_val),
`endif
    .idle     (idle)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // present one entry for a single cycle; returns at the negedge after the edge
  task automatic push_one(input logic [3:0] de, input logic [63:0] ve,
                          input logic [3:0] dm, input logic [63:0] vm);
    in_valid = 1'b1; in_dstE = de; in_valE = ve; in_dstM = dm; in_valM = vm;
    @(negedge clk);
    in_valid = 1'b0; in_dstE = 4'hF; in_valE = 64'd0; in_dstM = 4'hF; in_valM = 64'd0;
  endtask

  logic [3:0]  t_de [4] = '{4'd1, 4'd2, 4'd3, 4'd6};
  logic [63:0] t_ve [4] = '{64'd11, 64'd22, 64'd33, 64'd66};
  logic [3:0]  t_dm [4] = '{4'hF, 4'd5, 4'hF, 4'd7};
  logic [63:0] t_vm [4] = '{64'd0, 64'd55, 64'd0, 64'd77};

  initial begin
    rst = 1'b1; in_valid = 1'b0; wb_hold = 1'b0;
    in_dstE = 4'hF; in_valE = 64'd0; in_dstM = 4'hF; in_valM = 64'd0;
    q_srcA = 4'hF; q_srcB = 4'hF;
    repeat (2) @(negedge clk);

    check("rst_enA",   {63'd0, wr_enA}, 64'd0);
    check("rst_enB",   {63'd0, wr_enB}, 64'd0);
    check("rst_dstA",  {60'd0, wr_dstA}, 64'hF);
    check("rst_dstB",  {60'd0, wr_dstB}, 64'hF);
    check("rst_valA",  wr_valA, 64'd0);
    check("rst_valB",  wr_valB, 64'd0);
    check("rst_ready", {63'd0, in_ready}, 64'd0);
    check("rst_idle",  {63'd0, idle}, 64'd1);
    rst = 1'b0;
    #1 check("post_rst_ready", {63'd0, in_ready}, 64'd1);

    // single E write, one-cycle issue latency
    push_one(4'd3, 64'd100, 4'hF, 64'd0);
    q_srcA = 4'd3;
    #1;
    check("e_not_yet", {63'd0, wr_enA}, 64'd0);
    check("e_busy",    {63'd0, idle}, 64'd0);
    check("e_hazq",    {63'd0, hazA}, 64'd1);
    @(negedge clk);
    check("e_enA",  {63'd0, wr_enA}, 64'd1);
    check("e_dstA", {60'd0, wr_dstA}, 64'd3);
    check("e_valA", wr_valA, 64'd100);
    check("e_enB",  {63'd0, wr_enB}, 64'd0);
    check("e_hazw", {63'd0, hazA}, 64'd1);
    @(negedge clk);
    check("e_idle",  {63'd0, idle}, 64'd1);
    check("e_enA0",  {63'd0, wr_enA}, 64'd0);
    check("e_hold",  {60'd0, wr_dstA}, 64'd3);
    check("e_haz0",  {63'd0, hazA}, 64'd0);

    // dstE == dstM: M wins, E suppressed
    push_one(4'd4, 64'd8, 4'd4, 64'd50);
    q_srcA = 4'd4;
    #1 check("pop_haz", {63'd0, hazA}, 64'd1);
`ifdef WB_BYPASS_EN
    check("pop_fwd", fwdA_val, 64'd50);
`endif
    @(negedge clk);
    check("pop_enA",  {63'd0, wr_enA}, 64'd0);
    check("pop_enB",  {63'd0, wr_enB}, 64'd1);
    check("pop_dstB", {60'd0, wr_dstB}, 64'd4);
    check("pop_valB", wr_valB, 64'd50);
    @(negedge clk);
    check("pop_idle", {63'd0, idle}, 64'd1);

    // fill under hold, reject a 5th, then drain in order
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) push_one(t_de[i], t_ve[i], t_dm[i], t_vm[i]);
    #1 check("full_ready", {63'd0, in_ready}, 64'd0);
    push_one(4'd8, 64'd88, 4'hF, 64'd0);
    check("full_ready2", {63'd0, in_ready}, 64'd0);
    check("held_enA",    {63'd0, wr_enA}, 64'd0);
    wb_hold = 1'b0;
    #1 check("full_ready_pop", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("drain%0d_enA", i),  {63'd0, wr_enA}, 64'd1);
      check($sformatf("drain%0d_dstA", i), {60'd0, wr_dstA}, {60'd0, t_de[i]});
      check($sformatf("drain%0d_valA", i), wr_valA, t_ve[i]);
      check($sformatf("drain%0d_enB", i),  {63'd0, wr_enB}, (t_dm[i] != 4'hF) ? 64'd1 : 64'd0);
      if (t_dm[i] != 4'hF) begin
        check($sformatf("drain%0d_dstB", i), {60'd0, wr_dstB}, {60'd0, t_dm[i]});
        check($sformatf("drain%0d_valB", i), wr_valB, t_vm[i]);
      end
    end
    @(negedge clk);
    check("drain_idle", {63'd0, idle}, 64'd1);
    check("drain_enA0", {63'd0, wr_enA}, 64'd0);

    // hazard/forward with the younger M write overriding an older E write
    wb_hold = 1'b1;
    push_one(4'd2, 64'd7, 4'hF, 64'd0);
    push_one(4'hF, 64'd0, 4'd2, 64'd9);
    q_srcA = 4'd2; q_srcB = 4'hF;
    #1;
    check("haz_A", {63'd0, hazA}, 64'd1);
    check("haz_B", {63'd0, hazB}, 64'd0);
`ifdef WB_BYPASS_EN
    check("fwd_A", fwdA_val, 64'd9);
    check("fwd_B", fwdB_val, 64'd0);
`endif
    q_srcA = 4'd5;
    #1 check("haz_miss", {63'd0, hazA}, 64'd0);
    q_srcA = 4'hF;
    #1 check("haz_none", {63'd0, hazA}, 64'd0);
    wb_hold = 1'b0;
    @(negedge clk);
    check("hz_w1_enA", {63'd0, wr_enA}, 64'd1);
    check("hz_w1_val", wr_valA, 64'd7);
    @(negedge clk);
    check("hz_w2_enA", {63'd0, wr_enA}, 64'd0);
    check("hz_w2_enB", {63'd0, wr_enB}, 64'd1);
    check("hz_w2_val", wr_valB, 64'd9);
    @(negedge clk);

    // reset mid-operation discards pending entries
    wb_hold = 1'b1;
    push_one(4'd9, 64'd1, 4'hF, 64'd0);
    push_one(4'd10, 64'd2, 4'hF, 64'd0);
    push_one(4'd11, 64'd3, 4'd12, 64'd4);
    rst = 1'b1; wb_hold = 1'b0;
    in_valid = 1'b1; in_dstE = 4'd13; in_valE = 64'd5;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; in_dstE = 4'hF; in_valE = 64'd0;
    q_srcA = 4'd9; q_srcB = 4'd13;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("mrst%0d_en", i),   {62'd0, wr_enA, wr_enB}, 64'd0);
      check($sformatf("mrst%0d_dst", i),  {56'd0, wr_dstA, wr_dstB}, 64'hFF);
      check($sformatf("mrst%0d_idle", i), {63'd0, idle}, 64'd1);
      check($sformatf("mrst%0d_rdy", i),  {63'd0, in_ready}, 64'd1);
      check($sformatf("mrst%0d_haz", i),  {62'd0, hazA, hazB}, 64'd0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_issue.md
WB_ISSUE -- requirements
Module: wb_issue

Interface
REQ-001 SHALL provide parameter: DEPTH, 4, number of pending-writeback queue entries (power of two, 2..16).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  in  1  retiring instruction presents results.
REQ-005 SHALL have port: in_ready  out  1  queue can accept.
REQ-006 SHALL have ports: in_dstE  in  4, in_valE  in  64  E-result destination and value (4'hF = none).
REQ-007 SHALL have ports: in_dstM  in  4, in_valM  in  64  M-result destination and value (4'hF = none).
REQ-008 SHALL have ports: wr_enA  out  1, wr_dstA  out  4, wr_valA  out  64  register-file write port A (E path).
REQ-009 SHALL have ports: wr_enB  out  1, wr_dstB  out  4, wr_valB  out  64  register-file write port B (M path).
REQ-010 SHALL have port: wb_hold  in  1  suppresses issue while high.
REQ-011 SHALL have ports: q_srcA  in  4, q_srcB  in  4  decode source-register queries.
REQ-012 SHALL have ports: hazA  out  1, hazB  out  1  queried register has a pending write.
REQ-013 SHALL have ports, only with WB_BYPASS_EN: fwdA_val  out  64, fwdB_val  out  64  forwarded pending value.
REQ-014 SHALL have port: idle  out  1  queue empty and no write in flight.

Function
REQ-015 SHALL push {dstE,valE,dstM,valM} at an edge where in_valid && in_ready.
REQ-016 SHALL drive in_ready = (count < DEPTH) && !rst; a pop in the same cycle SHALL NOT make a full queue ready.
REQ-017 SHALL pop the head at an edge where count > 0 && !wb_hold and register it onto wr_* outputs (one write pair per cycle).
REQ-018 SHALL give latency: entry pushed at edge t into empty queue, wb_hold low -> wr_* valid during cycle after edge t+1.
REQ-019 SHALL drive, when no pop occurs, wr_enA = wr_enB = 0 for that next cycle; wr_dst*/wr_val* hold.
REQ-020 SHALL set wr_enA = (dstE != 4'hF) && !(dstE == dstM), and wr_enB = (dstM != 4'hF); on dstE == dstM != 4'hF (popq %rsp) the M value SHALL win.
REQ-021 SHALL never write register 15; dst 4'hF produces no enable.
REQ-022 SHALL compute hazX combinationally: q_srcX != 4'hF and equals any enabled dst of a valid queue entry or of the current wr_* stage.
REQ-023 SHALL keep count unchanged on simultaneous push and pop; pointers wrap modulo DEPTH.
REQ-024 SHALL drive idle = (count == 0) && !wr_enA && !wr_enB.

Reset
REQ-025 SHALL, with rst high at an edge: count and pointers 0; wr_enA/B 0; wr_dstA/B 4'hF; wr_valA/B 0; hazA/B 0.
REQ-026 SHALL discard all pending entries on reset mid-operation; no write issues for them; in_valid ignored while rst high.

Configuration
REQ-027 SHALL recognise macro WB_BYPASS_EN.
REQ-028 SHALL, with WB_BYPASS_EN defined, drive fwdX_val = value of youngest pending match (wr_* stage oldest, queue tail youngest; M over E within an entry), 0 when hazX low.
REQ-029 SHALL, without WB_BYPASS_EN, omit fwdA_val/fwdB_val ports and forwarding logic; hazX alone stalls decode.

Structure
REQ-030 SHALL take from shared package y86_pkg: RNONE = 4'hF, RSP = 4'hE, reg_id_t (4 bits), wb_entry_t {dstE,valE,dstM,valM}.
REQ-031 SHALL implement queue storage/pointers in sub-module wb_fifo; hazard/forward match logic and write-port stage in wb_issue.

Verification
REQ-032 SHALL cover: push {dstE=3,valE=100,dstM=F}, hold low -> wr_enA=1,wr_dstA=3,wr_valA=100 one cycle after the accept edge, wr_enB=0, then idle=1.
REQ-033 SHALL cover: push {dstE=4,valE=8,dstM=4,valM=50} -> wr_enA=0, wr_enB=1, wr_dstB=4, wr_valB=50.
REQ-034 SHALL cover: wb_hold=1, push 4 entries -> in_ready=0, 5th in_valid not accepted; release hold -> 4 writes on consecutive cycles in push order.
REQ-035 SHALL cover: pending dstE=2 valE=7 then dstM=2 valM=9 in queue, q_srcA=2 -> hazA=1; with WB_BYPASS_EN fwdA_val=9; q_srcB=F -> hazB=0.
REQ-036 SHALL cover: 3 entries pending, assert rst one cycle -> no wr_en pulses follow, wr_dst*=F, idle=1, in_ready=1 after rst drops.
